// File: rtl/seq_digit_multiplier.sv
// Sequential WIDTH x WIDTH multiplier: one DIGIT x DIGIT partial product per clock,
// with optional two's-complement operation and a busy/done handshake.
module seq_digit_multiplier #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic                 busy,
  output logic                 done_flag,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_out
);

  localparam int D  = WIDTH / DIGIT;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_param_check
      $error("seq_digit_multiplier: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Magnitude of an operand; the most negative value maps onto its unsigned twin.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ~v + WIDTH'(1'b1);
    end else begin
      return v;
    end
  endfunction

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic                   neg_q, neg_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [CW-1:0]          i_q, i_d, j_q, j_d;
  logic [2*WIDTH-1:0]     product_q, product_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [DIGIT-1:0]       a_sl_s, b_sl_s;
  logic [2*WIDTH-1:0]     pp_s;

  assign a_sl_s = a_q[int'(i_q) * DIGIT +: DIGIT];
  assign b_sl_s = b_q[int'(j_q) * DIGIT +: DIGIT];
  assign pp_s   = ((2*WIDTH)'(a_sl_s) * (2*WIDTH)'(b_sl_s)) << ((int'(i_q) + int'(j_q)) * DIGIT);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    i_d       = i_q;
    j_d       = j_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = magnitude(dataa, signed_mode);
          b_d     = magnitude(datab, signed_mode);
          neg_d   = signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = acc_q + pp_s;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d = S_SIGN;
          end else begin
            i_d = i_q + CW'(1'b1);
          end
        end else begin
          j_d = j_q + CW'(1'b1);
        end
      end
      S_SIGN: begin
        // A zero magnitude negates to zero, so a zero operand always yields +0.
        product_d = neg_q ? (~acc_q + (2*WIDTH)'(1'b1)) : acc_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy      = busy_q;
  assign done_flag = done_q;
  assign product   = product_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_seq_digit_multiplier.sv
// Scoreboard bench for seq_digit_multiplier: an 8x8 and a 16x16 instance share clock and reset.
module tb_seq_digit_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a;
  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic [1:0]  st8;
  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] prod16;
  logic [1:0]  st16;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last8  = 32'h0;
  logic [31:0] last16 = 32'h0;

  seq_digit_multiplier #(.WIDTH(8), .DIGIT(4)) u_dut8 (
    .clk(clk), .reset_a(reset_a), .start(start8), .signed_mode(sm8),
    .dataa(a8), .datab(b8), .busy(busy8), .done_flag(done8),
    .product(prod8), .state_out(st8)
  );

  seq_digit_multiplier #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .reset_a(reset_a), .start(start16), .signed_mode(sm16),
    .dataa(a16), .datab(b16), .busy(busy16), .done_flag(done16),
    .product(prod16), .state_out(st16)
  );

  function automatic logic obs_done(input bit w);
    return w ? done16 : done8;
  endfunction
  function automatic logic obs_busy(input bit w);
    return w ? busy16 : busy8;
  endfunction
  function automatic logic [1:0] obs_state(input bit w);
    return w ? st16 : st8;
  endfunction
  function automatic logic [31:0] obs_prod(input bit w);
    return w ? prod16 : {16'h0000, prod8};
  endfunction

  // Reference product from plain integer arithmetic.
  function automatic logic [31:0] model(input bit w, input bit sm,
                                        input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p;
    if (w) begin
      sa = sm ? longint'($signed(a)) : longint'(a);
      sb = sm ? longint'($signed(b)) : longint'(b);
      p  = sa * sb;
      return p[31:0];
    end else begin
      sa = sm ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      sb = sm ? longint'($signed(b[7:0])) : longint'(b[7:0]);
      p  = sa * sb;
      return {16'h0000, p[15:0]};
    end
  endfunction

  task automatic drive(input bit w, input bit st, input bit sm,
                       input logic [15:0] a, input logic [15:0] b);
    if (w) begin
      start16 = st; sm16 = sm; a16 = a; b16 = b;
    end else begin
      start8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // One operation; pulse_at > 1 re-pulses start with other operands at that edge count.
  task automatic run_op(input bit w, input bit sm, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] expv, input int lat, input int pulse_at,
                        input string name);
    logic [31:0] prev, want;
    int edges;
    bit seen;
    prev = w ? last16 : last8;
    exp_q.push_back(expv);
    drive(w, 1'b1, sm, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, ~sm, ~a, ~b);
    total++;
    if (obs_state(w) !== 2'd1 || obs_busy(w) !== 1'b1) begin
      bad++;
      $display("FAIL %s_accept: state=%0d busy=%b want state=1 busy=1", name, obs_state(w), obs_busy(w));
    end
    edges = 1;
    seen  = 1'b0;
    while (!seen && edges < lat + 10) begin
      if (edges == pulse_at) drive(w, 1'b1, ~sm, 16'h5A5A, 16'hA5A5);
      else if (edges == pulse_at + 1) drive(w, 1'b0, sm, a, b);
      @(posedge clk); #1;
      edges++;
      if (obs_done(w) === 1'b1) begin
        seen = 1'b1;
      end else begin
        total++;
        if (obs_prod(w) !== prev || obs_busy(w) !== 1'b1) begin
          bad++;
          $display("FAIL %s_hold: edge=%0d product=%h busy=%b want product=%h busy=1",
                   name, edges, obs_prod(w), obs_busy(w), prev);
        end
      end
    end
    total++;
    if (!seen || edges !== lat) begin
      bad++;
      $display("FAIL %s_latency: done at edge %0d (seen=%b) want edge %0d", name, edges, seen, lat);
    end
    want = exp_q.pop_front();
    total++;
    if (obs_prod(w) !== want || obs_busy(w) !== 1'b1 || obs_state(w) !== 2'd3) begin
      bad++;
      $display("FAIL %s_product: product=%h busy=%b state=%0d want product=%h busy=1 state=3",
               name, obs_prod(w), obs_busy(w), obs_state(w), want);
    end
    if (w) last16 = want; else last8 = want;
    @(posedge clk); #1;
    total++;
    if (obs_done(w) !== 1'b0 || obs_busy(w) !== 1'b0 || obs_state(w) !== 2'd0 || obs_prod(w) !== want) begin
      bad++;
      $display("FAIL %s_after: done=%b busy=%b state=%0d product=%h want 0 0 0 %h",
               name, obs_done(w), obs_busy(w), obs_state(w), obs_prod(w), want);
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    #12;
    total++;
    if (prod8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0 || st8 !== 2'd0) begin
      bad++;
      $display("FAIL reset8: product=%h busy=%b done=%b state=%0d want all 0", prod8, busy8, done8, st8);
    end
    @(posedge clk); #1;
    reset_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (prod16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0 || st16 !== 2'd0) begin
      bad++;
      $display("FAIL reset16: product=%h busy=%b done=%b state=%0d want all 0", prod16, busy16, done16, st16);
    end
  endtask

  task automatic test_unsigned8();
    run_op(1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 6, 0, "u8_ff_ff");
    run_op(1'b0, 1'b0, 16'h0080, 16'h0001, 32'h00000080, 6, 0, "u8_80_01");
  endtask

  task automatic test_signed8();
    run_op(1'b0, 1'b1, 16'h0080, 16'h0001, 32'h0000FF80, 6, 0, "s8_80_01");
    run_op(1'b0, 1'b1, 16'h0080, 16'h0080, 32'h00004000, 6, 0, "s8_80_80");
    run_op(1'b0, 1'b1, 16'h00FD, 16'h0007, 32'h0000FFEB, 6, 0, "s8_fd_07");
    run_op(1'b0, 1'b1, 16'h0000, 16'h0085, 32'h00000000, 6, 0, "s8_zero_neg");
    run_op(1'b0, 1'b1, 16'h00F9, 16'h00FA, 32'h0000002A, 6, 0, "s8_f9_fa");
  endtask

  task automatic test_wide16();
    run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 18, 0, "u16_ffff");
    run_op(1'b1, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 18, 0, "s16_8000_7fff");
  endtask

  task automatic test_ignore_start();
    run_op(1'b0, 1'b0, 16'h0012, 16'h0034, 32'h000003A8, 6, 3, "ignore8");
    run_op(1'b1, 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, 18, 7, "ignore16");
  endtask

  task automatic test_back_to_back();
    int edges, gap;
    logic [31:0] want;
    exp_q.push_back(32'h000000FF);
    drive(1'b0, 1'b1, 1'b0, 16'h000F, 16'h0011);
    edges = 0;
    while (done8 !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    want = exp_q.pop_front();
    total++;
    if (edges !== 6 || prod8 !== want[15:0]) begin
      bad++;
      $display("FAIL b2b_first: edges=%0d product=%h want edges=6 product=%h", edges, prod8, want[15:0]);
    end
    exp_q.push_back(32'h0000009C);
    drive(1'b0, 1'b1, 1'b0, 16'h000C, 16'h000D);
    @(posedge clk); #1;
    total++;
    if (st8 !== 2'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: state=%0d busy=%b done=%b want 0 0 0", st8, busy8, done8);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    total++;
    if (st8 !== 2'd1 || busy8 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_reaccept: state=%0d busy=%b want state=1 busy=1", st8, busy8);
    end
    gap = 2;
    while (done8 !== 1'b1 && gap < 30) begin
      @(posedge clk); #1;
      gap++;
    end
    want = exp_q.pop_front();
    total++;
    if (gap !== 7 || prod8 !== want[15:0]) begin
      bad++;
      $display("FAIL b2b_second: done-to-done=%0d product=%h want 7 product=%h", gap, prod8, want[15:0]);
    end
    last8 = want;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bit stray;
    drive(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h00FF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    reset_a = 1'b0;
    #1;
    total++;
    if (prod8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0 || st8 !== 2'd0 || prod16 !== 32'h0) begin
      bad++;
      $display("FAIL abort_async: product8=%h busy=%b done=%b state=%0d product16=%h want all 0",
               prod8, busy8, done8, st8, prod16);
    end
    @(posedge clk); #1;
    reset_a = 1'b1;
    last8  = 32'h0;
    last16 = 32'h0;
    stray  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0 || st8 !== 2'd0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL abort_no_done: stray activity=%b want 0", stray);
    end
    run_op(1'b0, 1'b0, 16'h0012, 16'h0034, 32'h000003A8, 6, 0, "abort_restart");
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    bit sm, w;
    for (int k = 0; k < 12; k++) begin
      w  = k[0];
      sm = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (!w) begin
        a[15:8] = 8'h00;
        b[15:8] = 8'h00;
      end
      run_op(w, sm, a, b, model(w, sm, a, b), w ? 18 : 6, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned8();
    test_signed8();
    test_wide16();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
